// File: rtl/deser_pkg.sv
// ============================================================================
// Module      : deser_pkg
// Description : Shared word/queue constants and FSM state type for the
//               deserializer datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package deser_pkg;

    localparam int WORD_W      = 8;
    localparam int QUEUE_DEPTH = 8;

    typedef enum logic [1:0] {
        RX   = 2'd0,
        WAIT = 2'd1,
        PUSH = 2'd2
    } deser_state_t;

endpackage

`default_nettype wire

// File: rtl/deserializer.sv
// ============================================================================
// Module      : deserializer
// Description : Serial-to-parallel front end. Assembles MSB-first words and
//               pushes each into the downstream byte queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = QUEUE_DEPTH
) (
    input  logic             clock_10k,
    input  logic             reset,
    input  logic             data_in,
    input  logic             write_in,
    input  logic [3:0]       queue_len_in,
    output logic [WIDTH-1:0] data_out,
    output logic             enq_out,
    output logic             status_out,
    output logic             err_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [3:0]       c_DEPTH    = 4'(DEPTH);

    deser_state_t     r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_enq;
    logic             r_status;
    logic             r_err;

    logic [WIDTH-1:0] w_shifted;

    assign w_shifted = {r_shreg[WIDTH-2:0], data_in};

    always_ff @(posedge clock_10k) begin
        if (reset) begin
            r_state  <= RX;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_enq    <= 1'b0;
            r_status <= 1'b1;
            r_err    <= 1'b0;
        end else begin
            // Bits offered while a word is still waiting to leave are dropped.
            r_err <= write_in && (r_state != RX);
            case (r_state)
                RX: begin
                    if (write_in) begin
                        r_shreg <= w_shifted;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST_BIT) begin
                            r_data   <= w_shifted;
                            r_status <= 1'b0;
                            r_state  <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (queue_len_in < c_DEPTH) begin
                        r_enq   <= 1'b1;
                        r_state <= PUSH;
                    end
                end
                PUSH: begin
                    r_enq    <= 1'b0;
                    r_status <= 1'b1;
                    r_state  <= RX;
                end
                default: begin
                    r_enq    <= 1'b0;
                    r_status <= 1'b1;
                    r_state  <= RX;
                end
            endcase
        end
    end

    assign data_out   = r_data;
    assign enq_out    = r_enq;
    assign status_out = r_status;
    assign err_out    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_deserializer.sv
// ============================================================================
// Module      : tb_deserializer
// Description : Self-checking bench for deserializer: vector table, directed
//               corner sequences and randomized traffic against a word model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_deserializer;
    import deser_pkg::*;

    logic       clock_10k = 1'b0;
    logic       reset;
    logic       data_in;
    logic       write_in;
    logic [3:0] queue_len_in;
    logic [7:0] data_out;
    logic       enq_out;
    logic       status_out;
    logic       err_out;

    deserializer #(.WIDTH(WORD_W), .DEPTH(QUEUE_DEPTH)) dut (
        .clock_10k    (clock_10k),
        .reset        (reset),
        .data_in      (data_in),
        .write_in     (write_in),
        .queue_len_in (queue_len_in),
        .data_out     (data_out),
        .enq_out      (enq_out),
        .status_out   (status_out),
        .err_out      (err_out)
    );

    always #5 clock_10k = ~clock_10k;

    int checks = 0;
    int errors = 0;

    // Reference: accepted bits accumulate arithmetically into a word; the
    // outputs follow the accept / wait-for-space / push timing rules.
    int         m_bits;
    int         m_acc;
    logic [7:0] m_data;
    logic       m_enq;
    logic       m_status;
    logic       m_err;

    int         n_enq;
    int         n_err;
    logic [7:0] cap[$];

    typedef struct {
        bit         w;
        bit         d;
        logic [7:0] e_data;
        bit         e_enq;
        bit         e_status;
        bit         e_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit w, input bit d, input int ql);
        if (rst) begin
            m_bits = 0; m_acc = 0; m_data = 8'h00;
            m_enq = 1'b0; m_status = 1'b1; m_err = 1'b0;
            return;
        end
        m_err = w && !m_status;
        if (m_status) begin
            if (w) begin
                m_acc  = ((m_acc * 2) + int'(d)) % 256;
                m_bits = m_bits + 1;
                if (m_bits == 8) begin
                    m_bits   = 0;
                    m_data   = 8'(m_acc);
                    m_status = 1'b0;
                end
            end
        end else if (m_enq) begin
            m_enq    = 1'b0;
            m_status = 1'b1;
        end else if (ql < QUEUE_DEPTH) begin
            m_enq = 1'b1;
        end
    endtask

    task automatic step(input bit rst, input bit w, input bit d, input int ql);
        reset        = rst;
        write_in     = w;
        data_in      = d;
        queue_len_in = 4'(ql);
        @(posedge clock_10k);
        model_edge(rst, w, d, ql);
        #1;
        check("data_out",   32'(data_out),   32'(m_data));
        check("enq_out",    32'(enq_out),    32'(m_enq));
        check("status_out", 32'(status_out), 32'(m_status));
        check("err_out",    32'(err_out),    32'(m_err));
        if (enq_out) begin
            n_enq++;
            cap.push_back(data_out);
        end
        if (err_out) n_err++;
    endtask

    task automatic send_word(input logic [7:0] wd, input int gap, input int ql);
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 1'b1, wd[i], ql);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, ql);
        end
    endtask

    task automatic idle(input int n, input int ql);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, ql);
    endtask

    vec_t       vecs[11];
    logic [7:0] words[3];
    logic [7:0] cur;

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0, 0);
        check("rst_data",   32'(data_out),   32'h00);
        check("rst_enq",    32'(enq_out),    32'h0);
        check("rst_status", 32'(status_out), 32'h1);
        check("rst_err",    32'(err_out),    32'h0);

        // 8'hA5 on consecutive cycles, queue empty
        vecs[0]  = '{1, 1, 8'h00, 0, 1, 0};
        vecs[1]  = '{1, 0, 8'h00, 0, 1, 0};
        vecs[2]  = '{1, 1, 8'h00, 0, 1, 0};
        vecs[3]  = '{1, 0, 8'h00, 0, 1, 0};
        vecs[4]  = '{1, 0, 8'h00, 0, 1, 0};
        vecs[5]  = '{1, 1, 8'h00, 0, 1, 0};
        vecs[6]  = '{1, 0, 8'h00, 0, 1, 0};
        vecs[7]  = '{1, 1, 8'hA5, 0, 0, 0};
        vecs[8]  = '{0, 0, 8'hA5, 1, 0, 0};
        vecs[9]  = '{0, 0, 8'hA5, 0, 1, 0};
        vecs[10] = '{0, 0, 8'hA5, 0, 1, 0};
        for (int i = 0; i < 11; i++) begin
            step(1'b0, vecs[i].w, vecs[i].d, 0);
            check($sformatf("vec%0d_data", i),   32'(data_out),   32'(vecs[i].e_data));
            check($sformatf("vec%0d_enq", i),    32'(enq_out),    32'(vecs[i].e_enq));
            check($sformatf("vec%0d_status", i), 32'(status_out), 32'(vecs[i].e_status));
            check($sformatf("vec%0d_err", i),    32'(err_out),    32'(vecs[i].e_err));
        end

        // 8'h3C with two idle cycles between bits
        n_enq = 0; cap.delete();
        send_word(8'h3C, 2, 0);
        idle(3, 0);
        check("gap_enq_count", 32'(n_enq), 32'd1);
        check("gap_word", (cap.size() > 0) ? 32'(cap[0]) : 32'hFFFF, 32'h3C);

        // 8'hFF into a full queue, three dropped bits while waiting
        n_enq = 0; n_err = 0; cap.delete();
        send_word(8'hFF, 0, 8);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8);
        idle(2, 8);
        check("full_no_enq", 32'(n_enq), 32'd0);
        check("full_err_count", 32'(n_err), 32'd3);
        idle(2, 7);
        check("full_enq_count", 32'(n_enq), 32'd1);
        check("full_word", (cap.size() > 0) ? 32'(cap[0]) : 32'hFFFF, 32'hFF);
        send_word(8'h01, 0, 0);
        idle(2, 0);
        check("after_full_data", 32'(data_out), 32'h01);
        check("after_full_enq", 32'(n_enq), 32'd2);

        // Reset after 5 bits of 8'hF0 discards them
        n_enq = 0; cap.delete();
        step(1'b0, 1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        send_word(8'h81, 0, 0);
        idle(2, 0);
        check("rstmid_data", 32'(data_out), 32'h81);
        check("rstmid_enq", 32'(n_enq), 32'd1);
        check("rstmid_word", (cap.size() > 0) ? 32'(cap[0]) : 32'hFFFF, 32'h81);

        // Back-to-back words, bits offered whenever the block accepts
        words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'h3C;
        cap.delete(); n_err = 0;
        begin
            int wi = 0;
            int bi = 7;
            int budget = 0;
            while (cap.size() < 3 && budget < 200) begin
                bit acc;
                acc = (wi < 3) && m_status;
                cur = (wi < 3) ? words[wi] : 8'h00;
                step(1'b0, acc, acc ? cur[bi] : 1'b0, cap.size());
                if (acc) begin
                    if (bi == 0) begin bi = 7; wi++; end
                    else bi--;
                end
                budget++;
            end
            check("b2b_timeout", 32'(budget < 200), 32'd1);
        end
        check("b2b_count", 32'(cap.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b_word%0d", i), (cap.size() > i) ? 32'(cap[i]) : 32'hFFFF, 32'(words[i]));
        check("b2b_no_err", 32'(n_err), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit r;
            int ql;
            r  = ($urandom_range(0, 199) == 0);
            ql = ($urandom_range(0, 3) == 0) ? 8 : int'($urandom_range(0, 7));
            step(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ql);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
